// File: rtl/led_level_meter.sv
// Log-scale LED bar meter: windowed peak magnitude of signed PCM, thermometer bar, sticky clip.
// Define LED_LEVEL_METER_PEAK_HOLD_EN to add the peak-hold dot with timed decay.
module led_level_meter #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_LEDS     = 16,
  parameter int UPDATE_DIV   = 12000000,
  parameter int HOLD_UPDATES = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sample_valid,
  input  logic [DATA_WIDTH-1:0]           sample_in,
  input  logic                            clear_clip,
  output logic [NUM_LEDS-1:0]             led,
  output logic [$clog2(NUM_LEDS+1)-1:0]   level,
  output logic                            update,
  output logic                            clip
);
  localparam int MW = DATA_WIDTH - 1;
  localparam int LW = $clog2(NUM_LEDS + 1);
  localparam int NW = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(UPDATE_DIV);

  // ceil(k*NUM_LEDS/MW) clamped; only ever evaluated on constants to fill the LUT
  function automatic int bar_of(input int k);
    int b;
    b = (k * NUM_LEDS + MW - 1) / MW;
    return (b > NUM_LEDS) ? NUM_LEDS : b;
  endfunction

  logic              is_min, is_max, tick;
  logic [DATA_WIDTH-1:0] neg;
  logic [MW-1:0]     mag, wmax, cmax;
  logic [CW-1:0]     cnt;
  logic [NW-1:0]     n;
  logic [LW-1:0]     bar;
  logic [NUM_LEDS-1:0] therm, dot;
  logic [DATA_WIDTH-1:0][LW-1:0] bar_lut;

  assign is_min = (sample_in == {1'b1, {MW{1'b0}}});
  assign is_max = (sample_in == {1'b0, {MW{1'b1}}});
  assign neg    = -sample_in;
  assign tick   = (cnt == CW'(UPDATE_DIV - 1));

  always_comb begin
    mag = sample_in[MW-1:0];
    if (is_min)                     mag = '1;
    else if (sample_in[DATA_WIDTH-1]) mag = neg[MW-1:0];
  end

  // A sample in the tick cycle still belongs to the closing window
  assign cmax = (sample_valid && (mag > wmax)) ? mag : wmax;

  always_comb begin
    n = '0;
    for (int i = 0; i < MW; i++)
      if (cmax[i]) n = NW'(i + 1);
  end

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lut
    assign bar_lut[g] = LW'(bar_of(g));
  end
  assign bar = bar_lut[n];

  always_comb begin
    therm = '0;
    for (int i = 0; i < NUM_LEDS; i++) therm[i] = (int'(bar) > i);
  end

`ifdef LED_LEVEL_METER_PEAK_HOLD_EN
  localparam int HW = (HOLD_UPDATES > 0) ? $clog2(HOLD_UPDATES + 1) : 1;
  logic [LW-1:0] pk, pk_next;
  logic [HW-1:0] hold, hold_next;

  always_comb begin
    pk_next   = pk;
    hold_next = hold;
    if (bar >= pk) begin
      pk_next   = bar;
      hold_next = HW'(HOLD_UPDATES);
    end else if (hold != '0) begin
      hold_next = hold - 1'b1;
    end else if (pk != '0) begin
      pk_next = pk - 1'b1;
    end
  end

  always_comb begin
    dot = '0;
    for (int i = 0; i < NUM_LEDS; i++) dot[i] = (pk_next != '0) && (int'(pk_next) - 1 == i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk   <= '0;
      hold <= '0;
    end else if (tick) begin
      pk   <= pk_next;
      hold <= hold_next;
    end
  end
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_UPDATES;
  assign dot = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      wmax   <= '0;
      clip   <= 1'b0;
      led    <= '0;
      level  <= '0;
      update <= 1'b0;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      update <= tick;
      if (tick)                             wmax <= '0;
      else if (sample_valid && mag > wmax)  wmax <= mag;
      if (sample_valid && (is_min || is_max)) clip <= 1'b1;
      else if (clear_clip)                    clip <= 1'b0;
      if (tick) begin
        level <= bar;
        led   <= therm | dot;
      end
    end
  end
endmodule

// File: tb/tb_led_level_meter.sv
// Directed bench for led_level_meter (16-bit samples, 16 LEDs, 16-cycle window, hold 2).
module tb_led_level_meter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic        clear_clip = 1'b0;
  logic [15:0] led;
  logic [4:0]  level;
  logic        update, clip;
  int checks = 0, failures = 0;
  int lat;

  led_level_meter #(.DATA_WIDTH(16), .NUM_LEDS(16), .UPDATE_DIV(16), .HOLD_UPDATES(2)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .clear_clip(clear_clip), .led(led), .level(level), .update(update), .clip(clip));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; sample_valid = 1'b0; clear_clip = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    sample_in = v; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Returns negedges waited until update is seen; 0 on timeout
  task automatic wait_upd(input string tag, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (update) begin n = i; break; end
    end
    if (n == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [15:0] exp4 [4];

  initial begin
`ifdef LED_LEVEL_METER_PEAK_HOLD_EN
    exp4 = '{16'h8000, 16'h8000, 16'h4000, 16'h2000};
`else
    exp4 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
    // 1: async reset mid-window
    do_reset;
    chk("t1_rst_level", 32'(level), 32'd0);
    send(16'h7FFF);
    chk("t1_clip", 32'(clip), 32'd1);
    sample_in = 16'h4000; sample_valid = 1'b1;
    wait_upd("t1a", lat);
    chk("t1a_level", 32'(level), 32'd16);
    chk("t1a_led", 32'(led), 32'hFFFF);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_led", 32'(led), 32'h0);
    chk("t1_async_level", 32'(level), 32'd0);
    chk("t1_async_clip", 32'(clip), 32'd0);
    @(negedge clk);
    sample_valid = 1'b0; rst = 1'b0;
    wait_upd("t1b", lat);
    chk("t1b_latency", 32'(lat), 32'd16);
    chk("t1b_level", 32'(level), 32'd0);
    chk("t1b_led", 32'(led), 32'h0);

    // 2: single mid-scale sample, one-cycle update
    do_reset;
    send(16'h0100);
    wait_upd("t2", lat);
    chk("t2_level", 32'(level), 32'd10);
    chk("t2_led", 32'(led), 32'h03FF);
    @(negedge clk);
    chk("t2_upd_pulse", 32'(update), 32'd0);
    chk("t2_led_stable", 32'(led), 32'h03FF);

    // 3: most-negative saturates; clip sticky, set beats clear
    do_reset;
    send(16'h8000);
    chk("t3_clip_set", 32'(clip), 32'd1);
    wait_upd("t3", lat);
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_led", 32'(led), 32'hFFFF);
    repeat (5) @(negedge clk);
    chk("t3_sticky", 32'(clip), 32'd1);
    sample_in = 16'h7FFF; sample_valid = 1'b1; clear_clip = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("t3_set_wins", 32'(clip), 32'd1);
    @(negedge clk);
    clear_clip = 1'b0;
    chk("t3_cleared", 32'(clip), 32'd0);
    send(16'h8001);
    chk("t3_no_clip", 32'(clip), 32'd0);

    // 4: peak hold and decay over silent windows
    do_reset;
    send(16'h7FFF);
    wait_upd("t4", lat);
    chk("t4_led0", 32'(led), 32'hFFFF);
    for (int w = 0; w < 4; w++) begin
      wait_upd("t4w", lat);
      chk($sformatf("t4_led%0d", w + 1), 32'(led), 32'(exp4[w]));
      chk($sformatf("t4_level%0d", w + 1), 32'(level), 32'd0);
    end

    // 5: sample on the tick cycle closes with its window
    do_reset;
    wait_upd("t5a", lat);
    chk("t5a_level", 32'(level), 32'd0);
    repeat (15) @(negedge clk);
    sample_in = 16'h0004; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("t5_update", 32'(update), 32'd1);
    chk("t5_level", 32'(level), 32'd4);
    chk("t5_led", 32'(led), 32'h000F);
    wait_upd("t5b", lat);
    chk("t5b_level", 32'(level), 32'd0);
`ifdef LED_LEVEL_METER_PEAK_HOLD_EN
    chk("t5b_led", 32'(led), 32'h0008);
`else
    chk("t5b_led", 32'(led), 32'h0000);
`endif

    // 6: mixed signs, largest magnitude wins
    do_reset;
    send(16'hFE00);
    send(16'h0010);
    wait_upd("t6", lat);
    chk("t6_level", 32'(level), 32'd11);
    chk("t6_led", 32'(led), 32'h07FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
